// File: rtl/bru_pkg.sv
// Shared types and encodings for the EX-stage branch resolver and its history table.
// Pure declarations; no logic, latency or flow control here.
package bru_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } bru_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

    localparam logic [1:0] FWD_DEC     = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;
    localparam logic [1:0] FWD_DEC_ALT = 2'd3;

    // 2-bit saturating counter step
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11)
            nxt = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Bimodal 2-bit counter table: combinational read, update lands on the next clock edge,
// so a same-index read in the update cycle returns the old value. Never stalls.
module bht_counter_table
    import bru_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IDXW = $clog2(ENTRIES);

    logic [1:0]      ctr [ENTRIES];
    logic [IDXW-1:0] rd_idx;
    logic [IDXW-1:0] upd_idx;
    logic            unused_pc_bits;

    // Word-aligned PCs: bits [1:0] carry no information
    assign rd_idx   = rd_pc[IDXW+1:2];
    assign upd_idx  = upd_pc[IDXW+1:2];
    assign rd_taken = ctr[rd_idx][1];

    assign unused_pc_bits = ^{rd_pc[XLEN-1:IDXW+2], rd_pc[1:0],
                              upd_pc[XLEN-1:IDXW+2], upd_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= 2'b01;
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: redirect and flush are registered (1 cycle after resolve),
// flush then holds FLUSH_CYCLES cycles; EX instructions seen during flush are squashed.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  bru_op_t         ex_op,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [1:0]      fwd_sel_a,
    input  logic [1:0]      fwd_sel_b,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] wb_value,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic [XLEN-1:0] bht_rd_pc,
    output logic            bht_rd_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    localparam int CNTW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(FLUSH_CYCLES - 1);

    bru_state_t      state;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] opa, opb, jalr_sum, target, seq_pc;
    logic            cond_taken, taken, mispredict, resolve;

    always_comb begin
        case (fwd_sel_a)
            FWD_MEM: opa = mem_alu_result;
            FWD_WB:  opa = wb_value;
            default: opa = ex_rs1;
        endcase
        case (fwd_sel_b)
            FWD_MEM: opb = mem_alu_result;
            FWD_WB:  opb = wb_value;
            default: opb = ex_rs2;
        endcase
    end

    always_comb begin
        case (ex_funct3)
            F3_BEQ:  cond_taken = (opa == opb);
            F3_BNE:  cond_taken = (opa != opb);
            F3_BLT:  cond_taken = ($signed(opa) <  $signed(opb));
            F3_BGE:  cond_taken = ($signed(opa) >= $signed(opb));
            F3_BLTU: cond_taken = (opa <  opb);
            F3_BGEU: cond_taken = (opa >= opb);
            default: cond_taken = 1'b0;
        endcase
    end

    assign jalr_sum   = opa + ex_imm;
    assign target     = (ex_op == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
    assign seq_pc     = ex_pc + XLEN'(4);
    assign taken      = (ex_op == BR_COND) ? cond_taken : (ex_op == BR_JAL || ex_op == BR_JALR);
    assign mispredict = (taken != pred_taken) || (taken && target != pred_target);
    assign resolve    = ex_valid && !ex_stall && ex_op != BR_NONE && state == IDLE;

    // The flush window counts down regardless of ex_stall: the front end is being squashed anyway
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    redirect_valid <= 1'b0;
                    if (resolve && mispredict) begin
                        state          <= FLUSH;
                        cnt            <= CNT_INIT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= taken ? target : seq_pc;
                        flush          <= 1'b1;
                    end
                end
                FLUSH: begin
                    redirect_valid <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (resolve) begin
            if (stat_branches != '1)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispred != '1)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end

    bht_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .XLEN    (XLEN)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (bht_rd_pc),
        .rd_taken  (bht_rd_taken),
        .upd_en    (resolve && ex_op == BR_COND),
        .upd_pc    (ex_pc),
        .upd_taken (taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect/flush expectations go through a
// scoreboard queue; stats and history-table reads are checked against bench-side models.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_stall;
    bru_op_t     ex_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [31:0] mem_alu_result, wb_value;
    logic        pred_taken;
    logic [31:0] pred_target, bht_rd_pc;
    logic        bht_rd_taken, redirect_valid, flush;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;

    branch_resolve_unit dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .mem_alu_result(mem_alu_result), .wb_value(wb_value),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .bht_rd_pc(bht_rd_pc), .bht_rd_taken(bht_rd_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_br        = 0;
    int   m_mp        = 0;
    logic [1:0] m_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Push the expected post-edge redirect/flush state, clock once, pop and compare
    task automatic cyc(input string tag, input logic erv, input logic [31:0] erpc, input logic efl);
        exp_t e;
        e.rv = erv; e.rpc = erpc; e.fl = efl;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.rv});
            chk({tag, "/flush"}, {31'd0, flush}, {31'd0, e.fl});
            if (e.rv) chk({tag, "/redirect_pc"}, redirect_pc, e.rpc);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "/stat_branches"}, stat_branches, m_br);
        chk({tag, "/stat_mispred"}, stat_mispred, m_mp);
    endtask

    task automatic br(input bru_op_t op, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_stall = 1'b0; ex_op = op; ex_funct3 = f3;
        ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_rs2 = rs2;
        fwd_sel_a = sa; fwd_sel_b = sb; pred_taken = pt; pred_target = ptgt;
    endtask

    task automatic nop();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_op = BR_NONE;
    endtask

    task automatic flush_tail(input string tag);
        nop();
        cyc({tag, "/f2"}, 1'b0, 32'h0, 1'b1);
        cyc({tag, "/end"}, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    initial begin
        reset = 1'b1; nop(); ex_funct3 = 3'd0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_rs2 = 0;
        fwd_sel_a = 0; fwd_sel_b = 0; mem_alu_result = 0; wb_value = 0;
        pred_taken = 0; pred_target = 0; bht_rd_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst/redirect_pc", redirect_pc, 32'd0);
        chk("rst/flush", {31'd0, flush}, 32'd0);
        chk_stats("rst");
        chk("rst/bht", {31'd0, bht_rd_taken}, 32'd0);
        reset = 1'b0;

        // BEQ with A forwarded from MEM; decode rs1 differs so forwarding must be used
        mem_alu_result = 32'd5;
        br(BR_COND, F3_BEQ, 32'h100, 32'h20, 32'd99, 32'd5, FWD_MEM, FWD_DEC, 1'b0, 32'h0);
        cyc("beq_fwd", 1'b1, 32'h120, 1'b1);
        m_br++; m_mp++;
        flush_tail("beq_fwd");
        chk_stats("beq_fwd");

        br(BR_COND, F3_BNE, 32'h200, 32'h40, 32'd7, 32'd7, FWD_DEC, FWD_DEC, 1'b1, 32'h240);
        cyc("bne_nt", 1'b1, 32'h204, 1'b1);
        m_br++; m_mp++;
        flush_tail("bne_nt");
        chk_stats("bne_nt");

        // -1 vs 1: signed less-than, unsigned greater
        br(BR_COND, F3_BLT, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd1, FWD_DEC, FWD_DEC, 1'b1, 32'h510);
        cyc("blt_ok", 1'b0, 32'h0, 1'b0); m_br++;
        br(BR_COND, F3_BLTU, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd1, FWD_DEC, FWD_DEC, 1'b0, 32'h0);
        cyc("bltu_ok", 1'b0, 32'h0, 1'b0); m_br++;
        br(BR_COND, F3_BGEU, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd1, FWD_DEC, FWD_DEC, 1'b0, 32'h0);
        cyc("bgeu_mp", 1'b1, 32'h510, 1'b1); m_br++; m_mp++;
        flush_tail("bgeu_mp");
        br(BR_COND, F3_BGE, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd1, FWD_DEC, FWD_DEC, 1'b1, 32'h510);
        cyc("bge_mp", 1'b1, 32'h504, 1'b1); m_br++; m_mp++;
        flush_tail("bge_mp");
        br(BR_COND, 3'b010, 32'h500, 32'h10, 32'd0, 32'd0, FWD_DEC, FWD_DEC, 1'b1, 32'h510);
        cyc("f3_undef", 1'b1, 32'h504, 1'b1); m_br++; m_mp++;
        flush_tail("f3_undef");
        chk_stats("cond_mix");

        // JALR via WB forward, LSB cleared: 0x1001+4 -> 0x1004
        wb_value = 32'h1001;
        br(BR_JALR, 3'd0, 32'h600, 32'd4, 32'd0, 32'd0, FWD_WB, FWD_DEC, 1'b1, 32'h1004);
        cyc("jalr_hit", 1'b0, 32'h0, 1'b0); m_br++;
        br(BR_JALR, 3'd0, 32'h600, 32'd4, 32'd0, 32'd0, FWD_WB, FWD_DEC, 1'b1, 32'h0);
        cyc("jalr_miss", 1'b1, 32'h1004, 1'b1); m_br++; m_mp++;
        flush_tail("jalr_miss");
        br(BR_JAL, 3'd0, 32'h300, 32'hFFFF_FFF8, 32'd0, 32'd0, FWD_DEC, FWD_DEC, 1'b0, 32'h0);
        cyc("jal_back", 1'b1, 32'h2F8, 1'b1); m_br++; m_mp++;
        flush_tail("jal_back");
        br(BR_JAL, 3'd0, 32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0, FWD_DEC, FWD_DEC, 1'b1, 32'h4);
        cyc("jal_wrap", 1'b0, 32'h0, 1'b0); m_br++;

        // Stalled or invalid mispredicting branch must not resolve
        br(BR_COND, F3_BEQ, 32'h100, 32'h20, 32'd1, 32'd1, FWD_DEC, FWD_DEC, 1'b0, 32'h0);
        ex_stall = 1'b1;
        cyc("stall", 1'b0, 32'h0, 1'b0);
        ex_stall = 1'b0; ex_valid = 1'b0;
        cyc("invalid", 1'b0, 32'h0, 1'b0);
        chk_stats("stall_inv");

        // History table at 0x40: 4 taken, 4 not-taken, 2 taken
        m_ctr = 2'b01;
        for (int i = 0; i < 10; i++) begin
            logic t;
            t = (i < 4) || (i >= 8);
            if (t) br(BR_COND, F3_BEQ, 32'h40, 32'h10, 32'd3, 32'd3, FWD_DEC, FWD_DEC, 1'b1, 32'h50);
            else   br(BR_COND, F3_BNE, 32'h40, 32'h10, 32'd3, 32'd3, FWD_DEC, FWD_DEC, 1'b0, 32'h0);
            #1;
            chk($sformatf("bht_war%0d", i), {31'd0, bht_rd_taken}, {31'd0, m_ctr[1]});
            cyc($sformatf("bht_upd%0d", i), 1'b0, 32'h0, 1'b0);
            m_ctr = sat(m_ctr, t); m_br++;
            chk($sformatf("bht_rd%0d", i), {31'd0, bht_rd_taken}, {31'd0, m_ctr[1]});
        end
        nop();
        chk_stats("bht");

        // Squash during flush, then back-to-back resolve once flush drops
        br(BR_COND, F3_BEQ, 32'h700, 32'h8, 32'd1, 32'd1, FWD_DEC, FWD_DEC, 1'b0, 32'h0);
        cyc("sq_first", 1'b1, 32'h708, 1'b1); m_br++; m_mp++;
        br(BR_COND, F3_BNE, 32'h800, 32'h40, 32'd2, 32'd2, FWD_DEC, FWD_DEC, 1'b1, 32'h840);
        cyc("sq_f1", 1'b0, 32'h0, 1'b1);
        cyc("sq_f2", 1'b0, 32'h0, 1'b0);
        chk_stats("sq");
        cyc("b2b", 1'b1, 32'h804, 1'b1); m_br++; m_mp++;
        chk_stats("b2b");

        // Reset while flushing
        nop(); reset = 1'b1;
        cyc("rst_flush", 1'b0, 32'h0, 1'b0);
        m_br = 0; m_mp = 0;
        chk_stats("rst_flush");
        for (int i = 0; i < 64; i++) begin
            bht_rd_pc = i * 4;
            #1;
            chk($sformatf("rst_bht%0d", i), {31'd0, bht_rd_taken}, 32'd0);
        end
        reset = 1'b0;
        cyc("post_rst", 1'b0, 32'h0, 1'b0);
        chk_stats("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
